// File: rtl/hja_led_capture.sv
// hja_led_capture
// Sits behind the debug LED mux. In live mode the debug word goes straight
// to the board LEDs. A debounced capture button logs {page, word} into a
// small ring buffer, and in frozen mode a debounced browse button steps
// through the captured entries, newest first. Two 7-segment digits show the
// page of whatever is currently on the LEDs.
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous reset, active-low
//   dbg_word   - 16-bit debug word from the LED mux
//   dbg_sel    - 8-bit page select currently driving the mux
//   freeze     - 0 = live mode, 1 = frozen/browse mode
//   btn_cap    - raw capture button (active-high, asynchronous)
//   btn_browse - raw browse button (active-high, asynchronous)
//   led_out    - word driven to the board LEDs (registered)
//   seg_hi     - high hex digit of displayed page, {g,f,e,d,c,b,a}
//   seg_lo     - low hex digit of displayed page, same encoding
//   cap_count  - number of valid entries, saturating at 2^DEPTH_LOG2
//   buf_full   - high when the buffer holds 2^DEPTH_LOG2 entries
//
// Optional feature, macro LED_CAP_AUTO_EN: while live, every cycle where
// dbg_word differs from its previous-cycle copy is also captured.

// Per-button synchronizer + debouncer producing a single-cycle pulse on the
// accepted rising edge.
module hja_led_capture_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic             r_accepted;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic             w_change;
  logic             w_accept;

  assign w_change = (r_sync2 != r_prev);
  assign w_accept = !w_change && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  // The armed flag only sets after a stable released level, so a button
  // held through reset has to be released and pressed again.
  assign o_pulse  = w_accept && r_sync2 && !r_accepted && r_armed;

  // Synchronize, watch for level changes and accept a level once it has
  // been stable long enough.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_prev     <= 1'b0;
      r_accepted <= 1'b0;
      r_armed    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (w_change) begin
        r_cnt <= '0;
      end else if (!w_accept) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_accepted <= r_sync2;
        if (!r_sync2) begin
          r_armed <= 1'b1;
        end
      end
    end
  end

endmodule

module hja_led_capture #(
  parameter int DEPTH_LOG2      = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           dbg_word,
  input  logic [7:0]            dbg_sel,
  input  logic                  freeze,
  input  logic                  btn_cap,
  input  logic                  btn_browse,
  output logic [15:0]           led_out,
  output logic [6:0]            seg_hi,
  output logic [6:0]            seg_lo,
  output logic [DEPTH_LOG2:0]   cap_count,
  output logic                  buf_full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  logic [23:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2-1:0] r_rdIdx;
  logic [DEPTH_LOG2:0]   r_capCount;
  logic                  r_freezeD;
  logic [15:0]           r_led;
  logic [6:0]            r_segHi;
  logic [6:0]            r_segLo;

  logic                  w_capPulse;
  logic                  w_brwPulse;
  logic                  w_capEvent;
  logic                  w_freezeRise;
  logic [DEPTH_LOG2-1:0] w_dispIdx;
  logic [23:0]           w_entry;

  function automatic logic [6:0] hexSeg(input logic [3:0] n);
    case (n)
      4'h0: hexSeg = 7'h3F;
      4'h1: hexSeg = 7'h06;
      4'h2: hexSeg = 7'h5B;
      4'h3: hexSeg = 7'h4F;
      4'h4: hexSeg = 7'h66;
      4'h5: hexSeg = 7'h6D;
      4'h6: hexSeg = 7'h7D;
      4'h7: hexSeg = 7'h07;
      4'h8: hexSeg = 7'h7F;
      4'h9: hexSeg = 7'h6F;
      4'hA: hexSeg = 7'h77;
      4'hB: hexSeg = 7'h7C;
      4'hC: hexSeg = 7'h39;
      4'hD: hexSeg = 7'h5E;
      4'hE: hexSeg = 7'h79;
      default: hexSeg = 7'h71;
    endcase
  endfunction

  hja_led_capture_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_capDeb (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_cap),
    .o_pulse (w_capPulse)
  );

  hja_led_capture_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_brwDeb (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_browse),
    .o_pulse (w_brwPulse)
  );

`ifdef LED_CAP_AUTO_EN
  logic [15:0] r_wordPrev;
  logic        r_autoArm;
  logic        w_autoCap;

  // The arm flag blocks the first cycle after reset, when r_wordPrev is
  // still the reset value rather than a real previous word.
  assign w_autoCap  = !freeze && r_autoArm && (dbg_word != r_wordPrev);
  assign w_capEvent = w_capPulse || w_autoCap;

  // Previous-cycle copy of the debug word for transition detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wordPrev <= '0;
      r_autoArm  <= 1'b0;
    end else begin
      r_wordPrev <= dbg_word;
      r_autoArm  <= 1'b1;
    end
  end
`else
  assign w_capEvent = w_capPulse;
`endif

  assign w_freezeRise = freeze && !r_freezeD;
  // rd_idx counts back from the newest entry, which sits just below wr_ptr.
  assign w_dispIdx    = r_wrPtr - 1'b1 - r_rdIdx;
  assign w_entry      = r_mem[w_dispIdx];

  // Ring buffer, browse index and registered output mux. Capture takes
  // priority over browse so a simultaneous browse pulse is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr    <= '0;
      r_rdIdx    <= '0;
      r_capCount <= '0;
      r_freezeD  <= 1'b0;
      r_led      <= '0;
      r_segHi    <= SEG_DASH;
      r_segLo    <= SEG_DASH;
    end else begin
      r_freezeD <= freeze;

      if (w_capEvent) begin
        r_mem[r_wrPtr] <= {dbg_sel, dbg_word};
        r_wrPtr        <= r_wrPtr + 1'b1;
        if (!r_capCount[DEPTH_LOG2]) begin
          r_capCount <= r_capCount + 1'b1;
        end
        r_rdIdx <= '0;
      end else if (w_freezeRise) begin
        r_rdIdx <= '0;
      end else if (w_brwPulse && freeze && (r_capCount != '0)) begin
        if ({1'b0, r_rdIdx} == r_capCount - 1'b1) begin
          r_rdIdx <= '0;
        end else begin
          r_rdIdx <= r_rdIdx + 1'b1;
        end
      end

      if (!freeze) begin
        r_led   <= dbg_word;
        r_segHi <= hexSeg(dbg_sel[7:4]);
        r_segLo <= hexSeg(dbg_sel[3:0]);
      end else if (r_capCount != '0) begin
        r_led   <= w_entry[15:0];
        r_segHi <= hexSeg(w_entry[23:20]);
        r_segLo <= hexSeg(w_entry[19:16]);
      end else begin
        r_led   <= '0;
        r_segHi <= SEG_DASH;
        r_segLo <= SEG_DASH;
      end
    end
  end

  assign led_out   = r_led;
  assign seg_hi    = r_segHi;
  assign seg_lo    = r_segLo;
  assign cap_count = r_capCount;
  assign buf_full  = r_capCount[DEPTH_LOG2];

endmodule

// File: tb/tb_hja_led_capture.sv
// tb_hja_led_capture
// Directed bench for hja_led_capture with a short debounce window. Live
// passthrough is table-driven; capture, wrap, browse, empty-buffer and
// simultaneous-pulse cases are hand-written sequences. With LED_CAP_AUTO_EN
// defined only the auto-capture sequence runs, since live-mode word changes
// would otherwise log extra entries.
module tb_hja_led_capture;

  localparam int DEB = 4;

  logic        clk;
  logic        rst;
  logic [15:0] dbgWord;
  logic [7:0]  dbgSel;
  logic        freeze;
  logic        btnCap;
  logic        btnBrowse;
  logic [15:0] ledOut;
  logic [6:0]  segHi;
  logic [6:0]  segLo;
  logic [3:0]  capCount;
  logic        bufFull;

  int checks;
  int errors;

  typedef struct {
    logic [7:0]  sel;
    logic [15:0] word;
    logic [15:0] expLed;
    logic [6:0]  expHi;
    logic [6:0]  expLo;
  } liveVec_t;

  liveVec_t vecs [5];

  hja_led_capture #(.DEPTH_LOG2(3), .DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .dbg_word   (dbgWord),
    .dbg_sel    (dbgSel),
    .freeze     (freeze),
    .btn_cap    (btnCap),
    .btn_browse (btnBrowse),
    .led_out    (ledOut),
    .seg_hi     (segHi),
    .seg_lo     (segLo),
    .cap_count  (capCount),
    .buf_full   (bufFull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] sel, input logic [15:0] word);
    @(negedge clk);
    dbgSel  = sel;
    dbgWord = word;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the chosen button(s) for hi cycles, then release long enough for
  // the release to be debounced as well.
  task automatic pressButtons(input logic cap, input logic brw, input int hi);
    @(negedge clk);
    btnCap    = cap;
    btnBrowse = brw;
    repeat (hi) @(negedge clk);
    btnCap    = 1'b0;
    btnBrowse = 1'b0;
    repeat (DEB + 8) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (DEB + 6) @(negedge clk);
  endtask

  task automatic checkFrozen(input string name, input logic [15:0] expLed);
    waitCycles(2);
    checkOutput(name, 32'(ledOut), 32'(expLed));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    dbgWord   = 16'h0000;
    dbgSel    = 8'h00;
    freeze    = 1'b0;
    btnCap    = 1'b0;
    btnBrowse = 1'b0;

    vecs[0] = '{sel: 8'h13, word: 16'hA5C3, expLed: 16'hA5C3, expHi: 7'h06, expLo: 7'h4F};
    vecs[1] = '{sel: 8'h20, word: 16'h0001, expLed: 16'h0001, expHi: 7'h5B, expLo: 7'h3F};
    vecs[2] = '{sel: 8'hFF, word: 16'hFFFF, expLed: 16'hFFFF, expHi: 7'h71, expLo: 7'h71};
    vecs[3] = '{sel: 8'h9B, word: 16'h1234, expLed: 16'h1234, expHi: 7'h6F, expLo: 7'h7C};
    vecs[4] = '{sel: 8'hDE, word: 16'h0000, expLed: 16'h0000, expHi: 7'h5E, expLo: 7'h79};

    repeat (2) @(negedge clk);
    checkOutput("reset led_out", 32'(ledOut), 32'h0);
    checkOutput("reset seg_hi", 32'(segHi), 32'h40);
    checkOutput("reset seg_lo", 32'(segLo), 32'h40);
    checkOutput("reset cap_count", 32'(capCount), 32'h0);
    checkOutput("reset buf_full", 32'(bufFull), 32'h0);
    rst = 1'b1;
    waitCycles(DEB + 6);

`ifdef LED_CAP_AUTO_EN
    // Word sequence 1,1,2,2,3 in live mode: two transitions logged.
    @(negedge clk);
    rst     = 1'b0;
    dbgSel  = 8'h20;
    dbgWord = 16'h0001;
    waitCycles(2);
    rst = 1'b1;
    waitCycles(1);
    dbgWord = 16'h0001;
    waitCycles(1);
    dbgWord = 16'h0002;
    waitCycles(1);
    dbgWord = 16'h0002;
    waitCycles(1);
    dbgWord = 16'h0003;
    waitCycles(3);
    checkOutput("auto cap_count", 32'(capCount), 32'h2);
    waitCycles(DEB + 4);
    freeze = 1'b1;
    checkFrozen("auto newest", 16'h0003);
    pressButtons(1'b0, 1'b1, 10);
    checkOutput("auto browse", 32'(ledOut), 32'h0002);
    checkOutput("auto cap_count after", 32'(capCount), 32'h2);
`else
    // Live passthrough vectors.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].word);
      @(posedge clk);
      #1;
      checkOutput($sformatf("live led_out %0d", i), 32'(ledOut), 32'(vecs[i].expLed));
      checkOutput($sformatf("live seg_hi %0d", i), 32'(segHi), 32'(vecs[i].expHi));
      checkOutput($sformatf("live seg_lo %0d", i), 32'(segLo), 32'(vecs[i].expLo));
    end

    // Bounce shorter than the debounce window is ignored.
    applyStimulus(8'h13, 16'hA5C3);
    pressButtons(1'b1, 1'b0, 2);
    checkOutput("short press count", 32'(capCount), 32'h0);
    pressButtons(1'b1, 1'b0, 10);
    checkOutput("long press count", 32'(capCount), 32'h1);

    // Ten more captures wrap the 8-entry buffer.
    for (int w = 1; w <= 10; w++) begin
      applyStimulus(8'h20, 16'(w));
      pressButtons(1'b1, 1'b0, 10);
    end
    freeze = 1'b1;
    checkFrozen("wrap newest", 16'h000A);
    checkOutput("wrap cap_count", 32'(capCount), 32'h8);
    checkOutput("wrap buf_full", 32'(bufFull), 32'h1);
    checkOutput("wrap seg_hi", 32'(segHi), 32'h5B);
    checkOutput("wrap seg_lo", 32'(segLo), 32'h3F);
    for (int b = 0; b < 7; b++) begin
      pressButtons(1'b0, 1'b1, 10);
    end
    checkOutput("browse x7", 32'(ledOut), 32'h0003);
    pressButtons(1'b0, 1'b1, 10);
    checkOutput("browse wrap", 32'(ledOut), 32'h000A);

    // Button held through reset must not capture until re-pressed.
    @(negedge clk);
    btnCap = 1'b1;
    rst    = 1'b0;
    waitCycles(3);
    rst = 1'b1;
    waitCycles(12);
    btnCap = 1'b0;
    waitCycles(DEB + 8);
    checkOutput("held through reset count", 32'(capCount), 32'h0);

    // Frozen with empty buffer: blank LEDs, dashes, browse ignored.
    checkFrozen("empty led_out", 16'h0000);
    checkOutput("empty seg_hi", 32'(segHi), 32'h40);
    checkOutput("empty seg_lo", 32'(segLo), 32'h40);
    pressButtons(1'b0, 1'b1, 10);
    checkOutput("empty browse led_out", 32'(ledOut), 32'h0000);
    checkOutput("empty browse seg_lo", 32'(segLo), 32'h40);
    checkOutput("empty browse count", 32'(capCount), 32'h0);

    // Capture while frozen, browse to rd_idx 3, then capture+browse together.
    for (int w = 1; w <= 5; w++) begin
      applyStimulus(8'h31, 16'h0100 + 16'(w));
      pressButtons(1'b1, 1'b0, 10);
    end
    checkOutput("frozen cap count", 32'(capCount), 32'h5);
    checkOutput("frozen cap newest", 32'(ledOut), 32'h0105);
    checkOutput("frozen cap seg_hi", 32'(segHi), 32'h4F);
    for (int b = 0; b < 3; b++) begin
      pressButtons(1'b0, 1'b1, 10);
    end
    checkOutput("rd_idx 3 entry", 32'(ledOut), 32'h0102);
    applyStimulus(8'h31, 16'h0BEE);
    pressButtons(1'b1, 1'b1, 10);
    checkOutput("simul count", 32'(capCount), 32'h6);
    checkOutput("simul led_out", 32'(ledOut), 32'h0BEE);
    checkOutput("simul buf_full", 32'(bufFull), 32'h0);
    pressButtons(1'b0, 1'b1, 10);
    checkOutput("after simul browse", 32'(ledOut), 32'h0105);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
